demux_1_4_sched: RTL and testbench

- Sequencing controller for the team's 1-to-4 demultiplexer (ports sel0, sel1, i, y0..y3).
- Accepts a single valid/ready input stream and buffers one word.
- Drives the demux select lines and delivers each word to one of four destination channels with a per-channel valid/ready handshake.
- Destination is chosen either round-robin or by an explicit address.

---
 rtl/demux_1_4_sched.sv | 95 +++++++++
 tb/tb_demux_1_4_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_sched.sv
// Sequencing controller for a 1-to-4 demux: buffers one valid/ready word and steers it to one
// of four channels (round-robin or addressed). Define DEMUX_SCHED_CNT_EN for per-channel delivery counters.
module demux_1_4_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic [3:0]   out_ready,
    output logic [3:0]   out_valid,
    output logic [W-1:0] out_data,
    output logic         sel0,
    output logic         sel1,
    output logic [1:0]   rr_ptr
`ifdef DEMUX_SCHED_CNT_EN
    ,
    input  logic         cnt_clr,
    output logic [31:0]  cnt
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q;
    logic [1:0]     sel_q;
    logic [1:0]     rr_q;
    logic [3:0]     valid_q;
    logic [W-1:0]   data_q;
    logic [1:0]     ch_d;
    logic           accept;
    logic           deliver;

    // Only the selected channel's ready matters; other out_ready bits are ignored.
    assign deliver = (state_q == HOLD) && out_ready[sel_q];
    assign ch_d    = mode ? in_sel : rr_q;
    assign accept  = in_valid && in_ready;

    // NOTE: default assignment first so every path drives in_ready and no latch is inferred.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) in_ready = en;
            else                 in_ready = en && out_ready[sel_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            rr_q    <= 2'd0;
            valid_q <= 4'd0;
            data_q  <= '0;
        end else if (accept) begin
            // An accept in HOLD coincides with a delivery, so the new word simply replaces the old one.
            state_q <= HOLD;
            data_q  <= in_data;
            sel_q   <= ch_d;
            valid_q <= 4'(1) << ch_d;
            if (!mode) rr_q <= rr_q + 2'd1;
        end else if (deliver) begin
            state_q <= IDLE;
            valid_q <= 4'd0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel0      = sel_q[0];
    assign sel1      = sel_q[1];
    assign rr_ptr    = rr_q;

`ifdef DEMUX_SCHED_CNT_EN
    logic [3:0][7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (deliver) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_4_sched.sv
// Directed self-checking bench for demux_1_4_sched; define DEMUX_SCHED_CNT_EN to also exercise the counters.
module tb_demux_1_4_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic       sel0;
    logic       sel1;
    logic [1:0] rr_ptr;
`ifdef DEMUX_SCHED_CNT_EN
    logic        cnt_clr;
    logic [31:0] cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demux_1_4_sched #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel0      (sel0),
        .sel1      (sel1),
        .rr_ptr    (rr_ptr)
`ifdef DEMUX_SCHED_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt       (cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
`ifdef DEMUX_SCHED_CNT_EN
        cnt_clr = 1'b0;
`endif
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_rr", 32'(rr_ptr), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Round-robin wrap, back-to-back
        mode = 1'b0; out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
            check("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            check("rr_sel", 32'({sel1, sel0}), 32'(i % 4));
            check("rr_data", 32'(out_data), 32'(8'hA0 + 8'(i)));
            check("rr_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("rr_drain_valid", 32'(out_valid), 32'h0);
        check("rr_end_ptr", 32'(rr_ptr), 32'd1);
        check("rr_sel_kept", 32'({sel1, sel0}), 32'd0);

        // Mid-transfer reset drops the held word
        mode = 1'b1; in_sel = 2'd2; in_data = 8'h33; in_valid = 1'b1; out_ready = 4'b0000;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'b0100);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_sel", 32'({sel1, sel0}), 32'd0);
        check("mid_rst_rr", 32'(rr_ptr), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Addressed with a 3-cycle stall; later input changes must not disturb the held word
        mode = 1'b1; in_sel = 2'd2; in_data = 8'h5C; in_valid = 1'b1; out_ready = 4'b0000;
        tick();
        in_data = 8'hFF; in_sel = 2'd1; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(out_valid), 32'b0100);
            check("stall_data", 32'(out_data), 32'h5C);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0; out_ready = 4'b0100;
        check("stall4_valid", 32'(out_valid), 32'b0100);
        check("stall4_data", 32'(out_data), 32'h5C);
        tick();
        check("stall_done_valid", 32'(out_valid), 32'h0);
        check("stall_rr", 32'(rr_ptr), 32'd0);

        // Wrong-channel ready is ignored
        mode = 1'b1; in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1; out_ready = 4'b1101;
        tick();
        in_valid = 1'b0;
        check("wrong_valid", 32'(out_valid), 32'b0010);
        check("wrong_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("wrong_hold_valid", 32'(out_valid), 32'b0010);
        check("wrong_hold_data", 32'(out_data), 32'h77);
        out_ready = 4'b0010;
        #1;
        check("right_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("right_done_valid", 32'(out_valid), 32'h0);
        check("right_idle_ready", 32'(in_ready), 32'd1);

        // Enable dropped on the delivery cycle
        mode = 1'b1; in_sel = 2'd3; in_data = 8'h99; in_valid = 1'b1; out_ready = 4'b0000;
        tick();
        check("en_hold_valid", 32'(out_valid), 32'b1000);
        en = 1'b0; out_ready = 4'b1000; in_data = 8'hAB;
        #1;
        check("en_off_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("en_off_delivered", 32'(out_valid), 32'h0);
        check("en_off_idle_ready", 32'(in_ready), 32'd0);
        tick();
        check("en_off_no_accept", 32'(out_valid), 32'h0);
        en = 1'b1;
        #1;
        check("en_on_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("en_on_valid", 32'(out_valid), 32'b1000);
        check("en_on_data", 32'(out_data), 32'hAB);
        in_valid = 1'b0;
        tick();
        check("en_on_done", 32'(out_valid), 32'h0);

`ifdef DEMUX_SCHED_CNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_cleared", cnt, 32'h0);
        mode = 1'b1; in_sel = 2'd3; out_ready = 4'b1000; in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("cnt_wrap", cnt, 32'h0100_0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", cnt, 32'h0);
        check("cnt_clr_delivered", 32'(out_valid), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
